// File: rtl/fifo_reader_if.sv
// Bundle of the control, FIFO read-port and downstream handshake signals of fifo_reader.
// The reader itself takes the master view; whoever feeds and consumes it takes the slave view.
interface fifo_reader_if #(
  parameter int DW   = 8,
  parameter int CNTW = 16
);
  logic            enable;
  logic            empty;
  logic [DW-1:0]   rdata;
  logic            renable;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic            busy;
  logic [CNTW-1:0] rd_count;

  modport master (
    input  enable, empty, rdata, m_ready,
    output renable, m_valid, m_data, busy, rd_count
  );

  modport slave (
    output enable, empty, rdata, m_ready,
    input  renable, m_valid, m_data, busy, rd_count
  );
endinterface

// File: rtl/fifo_reader.sv
// Drains a one-cycle-latency FIFO into a valid/ready stream through a 2-entry skid buffer,
// issuing reads only when the buffer is guaranteed to have room for the returning word.
module fifo_reader #(
  parameter int DW   = 8,
  parameter int CNTW = 16
) (
  input logic           rclk,
  input logic           rrst,
  fifo_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_inflight;
  logic [1:0]      r_occ;
  logic            r_valid;
  logic [DW-1:0]   r_buf0;
  logic [DW-1:0]   r_buf1;
  logic [CNTW-1:0] r_count;

  logic            w_pop;
  logic [2:0]      w_fill;
  logic            w_renable;

  // w_fill is the occupancy after this edge once the in-flight word lands; a new read is
  // only safe when that leaves a free slot for the word it will return next cycle.
  assign w_pop     = r_valid & bus.m_ready;
  assign w_fill    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_renable = (r_state == RUN) && !bus.empty && (w_fill < 3'd2);

  assign bus.renable  = w_renable;
  assign bus.m_valid  = r_valid;
  assign bus.m_data   = r_buf0;
  assign bus.busy     = r_busy;
  assign bus.rd_count = r_count;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.enable) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.enable) r_state <= DRAIN;
        end
        DRAIN: begin
          if (bus.enable) begin
            r_state <= RUN;
          end else if (!r_inflight && (r_occ == 2'd0)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage boundary: FIFO read port -> output buffer (word returns one edge after renable)
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_valid    <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_renable;
      r_occ      <= w_fill[1:0];
      r_valid    <= (w_fill != 3'd0);
      if (w_renable) r_count <= r_count + {{(CNTW-1){1'b0}}, 1'b1};
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= bus.rdata;
          else               r_buf1 <= bus.rdata;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
        end
        2'b11: begin
          // Head leaves while a word arrives: shift so order is preserved.
          if (r_occ == 2'd1) begin
            r_buf0 <= bus.rdata;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= bus.rdata;
          end
        end
        default: begin
          r_buf0 <= r_buf0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed and randomized bench for fifo_reader with a queue-based reference model.
module tb_fifo_reader;

  localparam int DW   = 8;
  localparam int CNTW = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic rclk;
  logic rrst;

  fifo_reader_if #(.DW(DW), .CNTW(CNTW)) bus ();

  fifo_reader #(.DW(DW), .CNTW(CNTW)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks;
  int errors;

  logic [DW-1:0] up_q[$];
  logic [DW-1:0] mdl_fifo[$];
  logic [DW-1:0] out_q[$];
  int            m_st;
  int            m_count;
  logic          m_inflight;
  int            ren_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    up_q.push_back(w);
    mdl_fifo.push_back(w);
    bus.empty = 1'b0;
  endtask

  task automatic cycle();
    int   occ;
    logic p_valid;
    logic p_pop;
    logic p_ren;
    logic ren_dut;
    logic done;
    #1;
    occ     = out_q.size() - (m_inflight ? 1 : 0);
    p_valid = (occ > 0);
    p_pop   = p_valid && bus.m_ready;
    p_ren   = (m_st == M_RUN) && (mdl_fifo.size() != 0) &&
              ((out_q.size() - (p_pop ? 1 : 0)) < 2);
    check("renable", 32'(bus.renable), 32'(p_ren));
    check("m_valid", 32'(bus.m_valid), 32'(p_valid));
    if (p_valid) check("m_data", 32'(bus.m_data), 32'(out_q[0]));
    check("busy", 32'(bus.busy), 32'(m_st != M_IDLE));
    check("rd_count", 32'(bus.rd_count), 32'(m_count % 16));
    ren_dut = bus.renable;
    if (ren_dut) ren_seen++;
    done = (out_q.size() == 0);
    case (m_st)
      M_IDLE:  if (bus.enable) m_st = M_RUN;
      M_RUN:   if (!bus.enable) m_st = M_DRAIN;
      default: if (bus.enable) m_st = M_RUN; else if (done) m_st = M_IDLE;
    endcase
    if (p_pop) void'(out_q.pop_front());
    if (p_ren) begin
      out_q.push_back(mdl_fifo.pop_front());
      m_count++;
    end
    m_inflight = p_ren;
    @(posedge rclk);
    @(negedge rclk);
    if (ren_dut && up_q.size() > 0) bus.rdata = up_q.pop_front();
    else                            bus.rdata = DW'($urandom);
    bus.empty = (up_q.size() == 0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"},  32'(bus.m_valid),  32'd0);
    check({tag, "_m_data"},   32'(bus.m_data),   32'd0);
    check({tag, "_rd_count"}, 32'(bus.rd_count), 32'd0);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_renable"},  32'(bus.renable),  32'd0);
  endtask

  initial begin
    int            saved;
    int            ren_before;
    logic [DW-1:0] head;
    checks = 0;
    errors = 0;
    m_st = M_IDLE;
    m_count = 0;
    m_inflight = 1'b0;
    ren_seen = 0;
    rrst = 1'b1;
    bus.enable  = 1'b1;
    bus.empty   = 1'b1;
    bus.rdata   = '0;
    bus.m_ready = 1'b1;

    // Power-on reset: outputs held at zero even with enable high.
    #3;
    check_reset_outputs("por");
    @(negedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
    bus.enable = 1'b0;

    // Streaming: 8 words at full rate.
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    bus.enable  = 1'b1;
    bus.m_ready = 1'b1;
    cycles(14);
    check("stream_count", 32'(bus.rd_count), 32'd8);

    // Backpressure: exactly two reads while downstream stalls.
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    ren_before = ren_seen;
    cycles(6);
    check("bp_pulses", 32'(ren_seen - ren_before), 32'd2);
    #1;
    check("bp_hold_valid", 32'(bus.m_valid), 32'd1);
    check("bp_hold_data",  32'(bus.m_data),  32'h01);
    bus.m_ready = 1'b1;
    cycles(8);

    // Drain: enable drops with words buffered and in flight.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(DW'(8'hA0 + i));
    cycles(2);
    bus.enable = 1'b0;
    cycles(2);
    bus.m_ready = 1'b1;
    cycles(6);
    #1;
    check("drain_idle_busy", 32'(bus.busy), 32'd0);

    // Enable toggles during drain.
    bus.enable = 1'b1;
    for (int i = 0; i < 6; i++) push_word(DW'(8'hC0 + i));
    cycles(3);
    bus.enable = 1'b0;
    cycles(1);
    bus.enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.m_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    bus.m_ready = 1'b1;
    cycles(6);

    // Empty guard: 20 cycles with nothing to read.
    saved = m_count;
    cycles(20);
    check("empty_guard_count", 32'(bus.rd_count), 32'(saved % 16));

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0 && up_q.size() < 20) push_word(DW'($urandom));
      bus.enable  = ($urandom_range(0, 9) != 0);
      bus.m_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    bus.enable  = 1'b1;
    bus.m_ready = 1'b1;
    cycles(30);

    // Reset mid-stream with the output buffer full.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(DW'(8'h50 + i));
    cycles(4);
    #2;
    rrst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    out_q.delete();
    m_inflight = 1'b0;
    m_st = M_IDLE;
    m_count = 0;
    @(posedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
    bus.rdata = DW'($urandom);
    head = mdl_fifo[0];
    bus.enable  = 1'b1;
    bus.m_ready = 1'b1;
    cycles(3);
    #1;
    check("post_rst_valid", 32'(bus.m_valid), 32'd1);
    check("post_rst_head",  32'(bus.m_data),  32'(head));
    cycles(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
